// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-7 (x^7 + x^6 + 1, XNOR feedback) generator and checker.
package prbs_pkg;

    localparam int PRBS7_W = 7;
    localparam int TAP_A   = 6;
    localparam int TAP_B   = 5;
    localparam int WIN_LEN = 32;

    // All-ones maps to itself under XNOR feedback, so it can never be a valid PRBS state.
    localparam logic [PRBS7_W-1:0] LOCKUP = 7'h7F;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic prbs_next(input logic [PRBS7_W-1:0] s);
        return s[TAP_A] ~^ s[TAP_B];
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS-7 state register with XNOR feedback; shifts in either the line bit or its own prediction.
module prbs7_lfsr
    import prbs_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic               load_bit,
    input  logic               use_load,
    input  logic               advance,
    output logic               pred_bit,
    output logic [PRBS7_W-1:0] state
);

    logic shift_bit;

    assign pred_bit  = prbs_next(state);
    assign shift_bit = use_load ? load_bit : pred_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (load_en || advance) begin
            state <= {state[PRBS7_W-2:0], shift_bit};
        end
    end

endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS-7 receive checker: hunts for lock on the line, then flags and counts
// bit errors against a free-running reference. Input handshake: a bit is taken whenever in_valid=1.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_ERR = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t             st;
    logic [2:0]         fill;
    logic [7:0]         run;
    logic [4:0]         win_pos;
    logic [5:0]         win_err;
    logic               pred_bit;
    logic [PRBS7_W-1:0] s;

    logic               mismatch;
    logic               qualify;
    logic [7:0]         run_inc;
    logic [5:0]         win_err_inc;

    // HUNT self-loads from the line; LOCKED runs free so line errors cannot corrupt the reference.
    prbs7_lfsr u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (in_valid && (st == HUNT)),
        .load_bit (in_bit),
        .use_load (st == HUNT),
        .advance  (in_valid && (st == LOCKED)),
        .pred_bit (pred_bit),
        .state    (s)
    );

    assign mismatch    = (in_bit != pred_bit);
    assign qualify     = (fill == 3'd7) && (s != LOCKUP);
    assign run_inc     = run + 8'd1;
    assign win_err_inc = win_err + {5'd0, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= HUNT;
            fill      <= '0;
            run       <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (clear) begin
                err_count <= '0;
            end
            if (in_valid) begin
                case (st)
                    HUNT: begin
                        if (fill != 3'd7) begin
                            fill <= fill + 3'd1;
                        end
                        if (qualify && !mismatch) begin
                            if (run_inc == 8'(LOCK_CNT)) begin
                                st      <= LOCKED;
                                locked  <= 1'b1;
                                run     <= '0;
                                win_pos <= '0;
                                win_err <= '0;
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        err_pulse <= mismatch;
                        // clear wins over a same-cycle increment
                        if (mismatch && !clear && (err_count != ERR_MAX)) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        win_pos <= win_pos + 5'd1;
                        if (win_err_inc >= 6'(UNLOCK_ERR)) begin
                            st      <= HUNT;
                            locked  <= 1'b0;
                            fill    <= '0;
                            run     <= '0;
                            win_pos <= '0;
                            win_err <= '0;
                        end else if (win_pos == 5'(WIN_LEN - 1)) begin
                            win_err <= '0;
                        end else begin
                            win_err <= win_err_inc;
                        end
                    end
                    default: st <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: an XNOR PRBS-7 transmitter model drives the line, expected
// outputs are queued per issued bit and compared by a separate monitor.
module tb_prbs7_checker;

    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_ERR = 4;
    localparam int ERR_W      = 4;
    localparam int EXP_W      = 32 + 2 + ERR_W;
    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_bit;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];

    int               cyc = 0;
    int               n_checks = 0;
    int               n_pass = 0;
    int               exp_pulses = 0;
    int               seen_pulses = 0;
    logic [6:0]       gen = 7'h00;
    logic [ERR_W-1:0] cnt_exp = '0;

    prbs7_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_ERR (UNLOCK_ERR),
        .ERR_W      (ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    // clock / cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_out(input string nm, input logic [ERR_W+1:0] act, input logic [ERR_W+1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got locked=%0b err_pulse=%0b err_count=%0d, want locked=%0b err_pulse=%0b err_count=%0d",
                      nm, cyc, act[ERR_W+1], act[ERR_W], act[ERR_W-1:0], exp[ERR_W+1], exp[ERR_W], exp[ERR_W-1:0]);
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    // transmit-side PRBS-7 model
    function automatic logic gen_bit();
        logic b;
        b   = gen[6] ~^ gen[5];
        gen = {gen[5:0], b};
        return b;
    endfunction

    // driver: queue the expectation for the outputs after this edge, then apply the inputs
    task automatic step(input logic v, input logic b, input logic c,
                        input logic lk, input logic pl, input logic [ERR_W-1:0] cnt, input string nm);
        exp_q.push_back({32'(cyc + 1), lk, pl, cnt});
        name_q.push_back(nm);
        if (pl) exp_pulses++;
        in_valid = v;
        in_bit   = b;
        clear    = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_clean(input int n, input logic lk, input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b1, gen_bit(), 1'b0, lk, 1'b0, cnt_exp, nm);
        end
    endtask

    task automatic send_err(input logic lk, input logic c, input string nm);
        logic b;
        b = gen_bit();
        if (c) cnt_exp = '0;
        else if (cnt_exp != CNT_MAX) cnt_exp = cnt_exp + 1'b1;
        step(1'b1, ~b, c, lk, 1'b1, cnt_exp, nm);
    endtask

    // 7 fill bits + LOCK_CNT matches: locked appears after the 15th bit
    task automatic relock(input string nm);
        send_clean(14, 1'b0, nm);
        send_clean(1, 1'b1, nm);
    endtask

    task automatic async_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_out("async_reset", {locked, err_pulse, err_count}, '0);
        @(negedge clk);
        rst_n   = 1'b1;
        cnt_exp = '0;
    endtask

    initial begin
        logic [EXP_W-1:0] e;
        string            nm;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clear    = 1'b0;

        // scoreboard monitor
        fork
            forever begin
                @(negedge clk);
                if (err_pulse) seen_pulses++;
                while (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) <= cyc) begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (int'(e[EXP_W-1 -: 32]) != cyc) check_int({nm, "_stale"}, int'(e[EXP_W-1 -: 32]), cyc);
                    else check_out(nm, {locked, err_pulse, err_count}, e[ERR_W+1:0]);
                end
            end
        join_none

        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, "reset_hold");
        rst_n = 1'b1;

        // clean stream from seed 0: lock after bit 15, no errors over 1000 bits
        relock("lock_clean");
        send_clean(985, 1'b1, "clean_run");
        for (int i = 0; i < 4; i++) step(1'b0, i[0], 1'b0, 1'b1, 1'b0, cnt_exp, "idle");

        // single error (window position 25)
        send_err(1'b1, 1'b0, "single_err");
        send_clean(40, 1'b1, "after_single");

        // 4 errors at window positions 2,4,6,8 -> unlock on the 4th
        send_err(1'b1, 1'b0, "unlock_e1");
        send_clean(1, 1'b1, "unlock_gap");
        send_err(1'b1, 1'b0, "unlock_e2");
        send_clean(1, 1'b1, "unlock_gap");
        send_err(1'b1, 1'b0, "unlock_e3");
        send_clean(1, 1'b1, "unlock_gap");
        send_err(1'b0, 1'b0, "unlock_e4");
        relock("relock1");

        // 3 errors at positions 29..31 and 3 at 0..2 straddle the window wrap: stay locked
        send_clean(29, 1'b1, "win_fill");
        for (int i = 0; i < 3; i++) send_err(1'b1, 1'b0, "win_tail");
        for (int i = 0; i < 3; i++) send_err(1'b1, 1'b0, "win_head");
        send_err(1'b0, 1'b0, "win_unlock");
        relock("relock2");

        // drive the 4-bit counter into saturation (20 errors in total)
        for (int i = 0; i < 3; i++) send_err(1'b1, 1'b0, "sat_run");
        send_err(1'b0, 1'b0, "sat_unlock");
        relock("relock3");
        for (int i = 0; i < 3; i++) send_err(1'b1, 1'b0, "sat_hold");
        send_err(1'b0, 1'b0, "sat_hold_unlock");
        relock("relock4");

        // clear coinciding with an error, then clear on an idle cycle
        send_err(1'b1, 1'b1, "clear_err");
        send_clean(1, 1'b1, "after_clear");
        send_err(1'b1, 1'b0, "count_after_clear");
        cnt_exp = '0;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cnt_exp, "clear_idle");
        send_err(1'b1, 1'b0, "count_after_idle_clear");

        // asynchronous reset while locked with a pulse showing
        async_reset();
        relock("relock_after_reset");
        send_clean(20, 1'b1, "post_reset_clean");

        // stuck-at-1 line must never lock
        async_reset();
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, "stuck_one");

        repeat (2) @(negedge clk);
        check_int("queue_drained", exp_q.size(), 0);
        check_int("pulse_total", seen_pulses, exp_pulses);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Receive-side PRBS-7 checker for serial link bring-up, paired with the XNOR-feedback PRBS-7 generator on the transmit end (polynomial x^7 + x^6 + 1). It self-synchronises to the incoming bit stream and tracks lock. Once locked, it flags every bit error and counts errors in a saturating counter. It sits after the deserializer/bit-sampler and reports to the link-status register block.

## Interface
- LOCK_CNT, default 8: consecutive predicted-bit matches in HUNT required to declare lock (range 1–255).
- UNLOCK_ERR, default 4: errors within one 32-bit window in LOCKED that force return to HUNT (range 1–32).
- ERR_W, default 16: width of err_count.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_bit is accepted on this cycle.
- in_bit  in  1  received serial bit.
- clear  in  1  synchronous clear of err_count (one-cycle pulse).
- locked  out  1  checker is in LOCKED state.
- err_pulse  out  1  one-cycle pulse: the last accepted bit mismatched while locked.
- err_count  out  ERR_W  saturating count of errors detected while locked.

## Operation
- LFSR state s[6:0]. Predicted bit p = s[6] XNOR s[5]. A bit is "accepted" when in_valid=1. Cycles with in_valid=0 change nothing except the clear action.
- The lockup state is 7'h7F: the all-ones state maps to itself under XNOR feedback.
- FSM states HUNT and LOCKED. Reset state is HUNT.
- **HUNT**
  - Each accepted bit: s <= {s[5:0], in_bit}, so the checker self-loads from the line.
  - fill counter saturates at 7. Comparisons count only once fill = 7.
  - Match (in_bit == p), with fill = 7 and s != 7'h7F: run += 1.
  - Mismatch, or s == 7'h7F: run <= 0. This prevents false lock on a stuck-at-1 line.
  - When run reaches LOCK_CNT: go to LOCKED; run, window counter and window error count clear.
- **LOCKED**
  - Each accepted bit: s <= {s[5:0], p}. The checker runs free, so line errors do not corrupt the reference.
  - Mismatch: err_pulse on the next cycle; err_count += 1, saturating at 2^ERR_W − 1; win_err += 1.
  - win_pos counts accepted bits 0..31. When it wraps to 0, win_err resets to 0.
  - If win_err reaches UNLOCK_ERR: go to HUNT, fill <= 0, run <= 0. The bit that triggers the unlock is still counted in err_count.
- **clear**
  - err_count <= 0. clear has priority over a same-cycle error increment; that error's err_pulse still fires.
  - clear does not affect FSM state, s, or the window counters.
- err_count is held, not cleared, on loss of lock.

## Timing
- Reset values: locked=0, err_pulse=0, err_count=0, s=7'h00, fill=0, run=0, win_pos=0, win_err=0.
- All outputs are registered. Latency from accepting a bit to any output effect is 1 cycle.
- locked rises the cycle after the LOCK_CNT-th qualifying match is accepted.
  - From a clean stream this is 7 + LOCK_CNT accepted bits after reset. The default is 15.
- locked falls the cycle after the UNLOCK_ERR-th error in the window is accepted. err_pulse for that bit appears in the same cycle.
- Back-to-back accepted bits are supported every cycle. There is no backpressure.
- rst_n asserted mid-stream: all state returns to reset values immediately (asynchronously). Hunting restarts on the first accepted bit after release.

## Structure
- Package prbs_pkg contains:
  - the state typedef {HUNT, LOCKED};
  - PRBS7_W = 7;
  - tap indices TAP_A = 6 and TAP_B = 5;
  - LOCKUP = 7'h7F;
  - WIN_LEN = 32.
- The generator shares the same package.
- Sub-module prbs7_lfsr holds the state register and XNOR feedback, and is reused by the generator. Its inputs are load_en, load_bit, use_load and advance. Its outputs are the predicted bit and the state.

## Test plan
- Clean stream: generator seeded at 7'h00, continuous valid → locked=1 on the cycle after the 15th bit; err_count stays 0 over 1000 bits.
- Single error injection: lock, then flip one bit → exactly one err_pulse one cycle later; err_count=1; locked stays 1; following bits produce no errors.
- Unlock: after lock, flip 4 bits within 32 bits → locked=0 one cycle after the 4th error; err_count=4. Resume a clean stream → relock after 15 more bits.
- Stuck-at-1 line: in_bit=1 continuously for 200 bits → locked never asserts.
- Saturation and clear: ERR_W=4, force 20 errors (relocking as needed) → err_count holds 15. clear coinciding with an error → err_count=0 and err_pulse=1.
- Reset mid-lock: assert rst_n low for 1 cycle while locked → locked=0 and err_count=0 immediately; relock after 15 clean bits.
